// File: rtl/rr_grant_arb.sv
// rr_grant_arb: round-robin grant arbiter with registered one-hot grant,
// grant index and an 8-bit accepted-grant counter.
// Optional feature: define RR_GRANT_ARB_LOCK_EN to add the lock input,
// the HOLD state and the hold counter (back-to-back locked re-grants).
module rr_grant_arb #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] mask,
  input  logic           ack,
`ifdef RR_GRANT_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [NCH-1:0] gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic [7:0]     gnt_cnt
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [NCH-1:0] gnt_d;
  logic           vld_d;
  logic [IDW-1:0] id_d;
  logic [CW-1:0]  cnt_d;
  logic [NCH-1:0] elig;
  logic           pick_ok;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] ptr_next;
  logic           lock_ok_c;

  assign elig = req & ~mask;

  // Pointer value after an accepted grant: one past the granted channel.
  assign ptr_next = (gnt_id == IDW'(NCH - 1)) ? '0 : IDW'(gnt_id + 1'b1);

`ifdef RR_GRANT_ARB_LOCK_EN
  logic [CW-1:0] hold_q, hold_d;

  assign lock_ok_c = lock && req[gnt_id] && !mask[gnt_id] &&
                     (hold_q < CW'(HOLD_MAX - 1));

  // Hold count: steps on each locked re-grant, clears whenever the run ends.
  always_comb begin
    hold_d = hold_q;
    if (state_q != IDLE) begin
      if (ack)               hold_d = lock_ok_c ? CW'(hold_q + 1'b1) : '0;
      else if (!req[gnt_id]) hold_d = '0;
    end
  end

  // Hold count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign lock_ok_c = 1'b0;
`endif

  // First eligible channel searching upward from ptr, wrapping at NCH-1.
  always_comb begin
    int unsigned j;
    j       = 0;
    pick_ok = 1'b0;
    pick_id = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      j = (32'(ptr_q) + i) % NCH;
      if (!pick_ok && elig[j]) begin
        pick_ok = 1'b1;
        pick_id = IDW'(j);
      end
    end
  end

  // Next state, pointer, counter and grant outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    vld_d   = gnt_vld;
    id_d    = gnt_id;
    cnt_d   = gnt_cnt;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = GRANT;
          vld_d   = 1'b1;
          id_d    = pick_id;
        end else begin
          vld_d   = 1'b0;
          id_d    = '0;
        end
      end
      GRANT, HOLD: begin
        if (ack) begin
          cnt_d = CW'(gnt_cnt + 1'b1);
          if (lock_ok_c) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            ptr_d   = ptr_next;
            vld_d   = 1'b0;
            id_d    = '0;
          end
        end else if (!req[gnt_id]) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          id_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        id_d    = '0;
      end
    endcase
    gnt_d = vld_d ? (NCH'(1) << id_d) : '0;
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
      gnt_cnt <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      gnt_vld <= vld_d;
      gnt_id  <= id_d;
      gnt_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_arb.sv
// Bench for rr_grant_arb: directed literal checks plus randomized traffic
// compared every cycle against a behavioural owner/pointer model.
module tb_rr_grant_arb;

  localparam int NCH = 4;
  localparam int IDW = 2;
`ifdef RR_GRANT_ARB_LOCK_EN
  localparam int HOLD    = 3;
  localparam bit LOCK_ON = 1'b1;
`else
  localparam int HOLD    = 8;
  localparam bit LOCK_ON = 1'b0;
`endif

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] req   = '0;
  logic [NCH-1:0] mask  = '0;
  logic           ack   = 1'b0;
  logic           lock  = 1'b0;
  logic [NCH-1:0] gnt;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [7:0]     gnt_cnt;

  int checks = 0;
  int errors = 0;

  // Model: owning channel (-1 = none), search pointer, counter, locked run length.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_run = 0;

  int rot_exp[10] = '{1, 0, 2, 0, 4, 0, 8, 0, 1, 0};

  always #5 clk = ~clk;

  rr_grant_arb #(.NCH(NCH), .IDW(IDW), .HOLD_MAX(HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .mask   (mask),
    .ack    (ack),
`ifdef RR_GRANT_ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .gnt_vld(gnt_vld),
    .gnt_id (gnt_id),
    .gnt_cnt(gnt_cnt)
  );

  task automatic model_reset();
    m_own = -1;
    m_ptr = 0;
    m_cnt = 0;
    m_run = 0;
  endtask

  // One clock edge worth of arbitration rules applied to the held inputs.
  task automatic model_step();
    int c;
    if (m_own < 0) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (m_own < 0 && req[c] && !mask[c]) m_own = c;
      end
    end else if (ack) begin
      m_cnt = (m_cnt + 1) % 256;
      if (lock && req[m_own] && !mask[m_own] && m_run < HOLD - 1) begin
        m_run++;
      end else begin
        m_ptr = (m_own + 1) % NCH;
        m_own = -1;
        m_run = 0;
      end
    end else if (!req[m_own]) begin
      m_own = -1;
      m_run = 0;
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] eg;
    logic           ev;
    logic [IDW-1:0] ei;
    logic [7:0]     ec;
    ev = (m_own >= 0);
    eg = ev ? NCH'(1 << m_own) : '0;
    ei = ev ? IDW'(m_own) : '0;
    ec = 8'(m_cnt);
    checks++;
    if (gnt !== eg || gnt_vld !== ev || gnt_id !== ei || gnt_cnt !== ec) begin
      errors++;
      $display("FAIL model t=%0t gnt=%b exp %b vld=%b exp %b id=%0d exp %0d cnt=%0d exp %0d",
               $time, gnt, eg, gnt_vld, ev, gnt_id, ei, gnt_cnt, ec);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one posedge, step the model, compare at the falling edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    compare();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_vld", int'(gnt_vld), 0);
    chk("rst_cnt", int'(gnt_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_id", int'(gnt_id), 0);

    // Rotation with ack tied high: grant every second cycle.
    req = 4'b1111; ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rot_gnt", int'(gnt), rot_exp[k]);
    end
    chk("rot_cnt", int'(gnt_cnt), 5);

    // Withdrawal leaves ptr and counter untouched.
    do_reset();
    req = 4'b0010; ack = 1'b0;
    tick(); chk("wd_g1", int'(gnt), 2);
    ack = 1'b1;
    tick(); chk("wd_idle", int'(gnt_vld), 0);
    req = 4'b0100; ack = 1'b0;
    tick(); chk("wd_g2", int'(gnt), 4);
    req = 4'b0000;
    tick(); chk("wd_drop", int'(gnt), 0);
    chk("wd_cnt", int'(gnt_cnt), 1);
    req = 4'b1100;
    tick(); chk("wd_regrant", int'(gnt_id), 2);

    // Mask during an active grant does not disturb it.
    do_reset();
    req = 4'b0010; ack = 1'b0;
    tick(); chk("mk_g", int'(gnt), 2);
    req = 4'b0011; mask = 4'b0010;
    tick(); chk("mk_hold", int'(gnt), 2);
    ack = 1'b1;
    tick(); chk("mk_acc", int'(gnt_vld), 0);
    ack = 1'b0;
    tick(); chk("mk_skip", int'(gnt), 1);

    // Reset in the middle of a grant, then lowest eligible wins.
    chk("pre_rst_vld", int'(gnt_vld), 1);
    do_reset();
    req = 4'b0110; mask = 4'b0000; ack = 1'b0;
    tick(); chk("post_rst_gnt", int'(gnt), 2);

    // Counter wraps after 256 accepted grants.
    do_reset();
    req = 4'b0001; ack = 1'b1;
    for (int k = 0; k < 510; k++) tick();
    chk("cnt_255", int'(gnt_cnt), 255);
    tick(); tick();
    chk("cnt_wrap", int'(gnt_cnt), 0);

`ifdef RR_GRANT_ARB_LOCK_EN
    // Locked run of HOLD grants, one gap, then the next channel.
    do_reset();
    req = 4'b0011; ack = 1'b1; lock = 1'b1;
    tick(); chk("lk_0", int'(gnt), 1);
    tick(); chk("lk_1", int'(gnt), 1);
    tick(); chk("lk_2", int'(gnt), 1);
    tick(); chk("lk_gap", int'(gnt), 0);
    tick(); chk("lk_next", int'(gnt), 2);
    lock = 1'b0;
`endif

    // Randomized traffic with sticky requests and occasional resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      req  = req ^ NCH'($urandom & $urandom);
      mask = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      ack  = ($urandom_range(0, 2) != 0);
      lock = LOCK_ON && ($urandom_range(0, 3) != 0);
      tick();
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_arb.md
RR_GRANT_ARB -- requirements
Module: rr_grant_arb

Interface
REQ-001 Parameter NCH, default 4, sets the number of request channels; legal range is 2..16.
REQ-002 Parameter IDW, default 2, sets the channel index width and SHALL equal ceil(log2(NCH)).
REQ-003 Parameter HOLD_MAX, default 8, sets the maximum consecutive locked grants per channel; legal range is 1..255.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NCH  per-channel request, level-sensitive.
REQ-007 mask  input  NCH  per-channel disable; 1 excludes that channel from new arbitration.
REQ-008 ack  input  1  consumer accepts the current grant.
REQ-009 lock  input  1  requests back-to-back re-grant of the current channel; present only with LOCK_EN.
REQ-010 gnt  output  NCH  one-hot grant; all zero when no grant is active.
REQ-011 gnt_vld  output  1  a grant is active.
REQ-012 gnt_id  output  IDW  index of the granted channel; 0 when gnt_vld=0.
REQ-013 gnt_cnt  output  8  accepted-grant counter; wraps modulo 256.

Function
REQ-014 Eligible set: req & ~mask.
REQ-015 FSM states: IDLE, GRANT, HOLD.
REQ-016 IDLE: if the eligible set is nonzero, select the first eligible channel searching upward from ptr with wrap NCH-1->0; enter GRANT; gnt/gnt_vld/gnt_id registered, visible the cycle after req is sampled (latency 1).
REQ-017 GRANT: outputs stay stable until ack=1 or req[gnt_id]=0; changes to mask or to other channels' req SHALL NOT alter the active grant.
REQ-018 GRANT with ack=1: gnt_cnt increments; ptr becomes (gnt_id+1) mod NCH; next state is IDLE, or HOLD under REQ-028.
REQ-019 GRANT with req[gnt_id]=0 and ack=0: grant withdrawn next cycle, ptr unchanged, gnt_cnt unchanged, next state IDLE.
REQ-020 Same cycle ack=1 and req[gnt_id]=0: treated as accepted (REQ-018).
REQ-021 IDLE always spends one cycle with gnt_vld=0 between non-locked grants.
REQ-022 Only one channel eligible: it is re-granted after each IDLE cycle, regardless of ptr.
REQ-023 gnt SHALL be one-hot or zero in every cycle; gnt_id SHALL match gnt.

Reset
REQ-024 When rst_n=0, the block SHALL immediately and asynchronously clear gnt, gnt_vld, gnt_id, gnt_cnt, ptr and the hold count, and set the state to IDLE.
REQ-025 A reset during GRANT or HOLD drops the grant immediately and does not increment gnt_cnt.
REQ-026 The first arbitration after reset release starts its search at channel 0.

Configuration
REQ-027 Macro RR_GRANT_ARB_LOCK_EN compiles in the lock port, the HOLD state and the hold counter.
REQ-028 With the macro: ack=1 with lock=1, req[gnt_id]=1, mask[gnt_id]=0 and hold count < HOLD_MAX-1 enters HOLD; the grant stays on the same channel with no gap cycle; the hold count increments; ptr is not advanced until the locked run ends.
REQ-029 HOLD behaves like GRANT per REQ-017..REQ-020; a run ends when lock=0 at ack, the channel is masked or drops req, or the count reaches HOLD_MAX-1; the count clears on return to IDLE.
REQ-030 Without the macro: the lock port is absent, HOLD is unreachable, and behaviour is REQ-014..REQ-023 only.

Verification
REQ-031 Reset release, req=4'b1111, ack tied high -> grants 0,1,2,3,0 on every second cycle; gnt_cnt=5 after five grants.
REQ-032 Grant to ch2 active, req[2] dropped with ack=0 -> gnt=0 next cycle; gnt_cnt unchanged; next grant is ch2 again if re-requested (ptr unchanged).
REQ-033 Grant to ch1 active, mask=4'b0010 asserted -> grant held until ack; the next eligible grant skips ch1.
REQ-034 rst_n pulsed low mid-GRANT -> gnt/gnt_vld/gnt_cnt read 0 in the same cycle; the first post-reset grant goes to the lowest eligible channel.
REQ-035 LOCK_EN, HOLD_MAX=3, lock=1, ack=1, req=4'b0011 -> ch0 is granted 3 consecutive cycles with no gap, then one IDLE cycle, then ch1.
REQ-036 gnt_cnt driven through 256 acks -> wraps to 0 with no error flag.
